// File: rtl/rc_fork_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rc_fork_ctrl
// Purpose  : Per-input-port route compute, port allocation and wormhole fork
//            controller (forward copy plus local absorb copy).
// Revision : 1.0
// ============================================================================
module rc_fork_ctrl #(
    parameter int FLIT_W     = 66,
    parameter int PORTW      = 2,
    parameter int LOCAL_PORT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              dec_um_type,
    output logic [10:0]       dec_addr0,
    output logic [55:0]       dec_addr1,
    input  logic [PORTW:0]    dec_port,
    input  logic [55:0]       dec_addr1_rm,
    input  logic              dec_fwdab_en,
    output logic              req_fwd,
    output logic              req_abs,
    input  logic              gnt_fwd,
    input  logic              gnt_abs,
    output logic              release_ports,
    output logic              fwd_valid,
    output logic [PORTW:0]    fwd_port,
    output logic [FLIT_W-1:0] fwd_flit,
    input  logic              fwd_ready,
    output logic              abs_valid,
    output logic [FLIT_W-1:0] abs_flit,
    input  logic              abs_ready,
    output logic              err
);

    localparam logic [PORTW:0] c_local_port = LOCAL_PORT[PORTW:0];

    typedef enum logic [1:0] {
        c_idle  = 2'd0,
        c_route = 2'd1,
        c_alloc = 2'd2,
        c_xfer  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [56:0] r_hdr;       // UM_TYPE plus address field of the pending head
    logic        r_fab;
    logic [55:0] r_rm;
    logic        r_fwd_got;
    logic        r_abs_got;
    logic        w_fwd_got_nx;
    logic        w_abs_got_nx;
    logic        w_fab_nx;
    logic        w_xfer;
    logic        w_is_head;
    logic        w_is_tail;

    // Types 01/11 carry a head, types 10/11 end the packet.
    assign w_is_head = in_flit[64];
    assign w_is_tail = in_flit[65];

    assign dec_um_type = r_hdr[56];
    assign dec_addr0   = r_hdr[56] ? 11'd0 : r_hdr[55:45];
    assign dec_addr1   = r_hdr[56] ? r_hdr[55:0] : 56'd0;

    // A fork onto the local port itself would request the same port twice.
    assign w_fab_nx = (r_state == c_route) ? (dec_fwdab_en && (dec_port != c_local_port))
                                           : r_fab;

    always_comb begin
        w_state_nx   = r_state;
        in_ready     = 1'b0;
        fwd_valid    = 1'b0;
        abs_valid    = 1'b0;
        w_fwd_got_nx = r_fwd_got;
        w_abs_got_nx = r_abs_got;
        w_xfer       = 1'b0;
        case (r_state)
            c_idle: begin
                if (in_valid) begin
                    if (w_is_head) w_state_nx = c_route;
                    else           in_ready   = 1'b1;
                end
            end
            c_route: w_state_nx = c_alloc;
            c_alloc: begin
                w_fwd_got_nx = r_fwd_got | gnt_fwd;
                w_abs_got_nx = r_abs_got | gnt_abs;
                if (w_fwd_got_nx && (w_abs_got_nx || !r_fab)) w_state_nx = c_xfer;
            end
            c_xfer: begin
                // Each copy is offered only when the other side can take it too.
                if (r_fab) begin
                    fwd_valid = in_valid && abs_ready;
                    abs_valid = in_valid && fwd_ready;
                    in_ready  = fwd_ready && abs_ready;
                end else begin
                    fwd_valid = in_valid;
                    in_ready  = fwd_ready;
                end
                w_xfer = in_valid && in_ready;
                if (w_xfer && w_is_tail) begin
                    w_state_nx   = c_idle;
                    w_fwd_got_nx = 1'b0;
                    w_abs_got_nx = 1'b0;
                end
            end
            default: w_state_nx = c_idle;
        endcase
    end

    always_comb begin
        fwd_flit = '0;
        abs_flit = '0;
        if (r_state == c_xfer) begin
            fwd_flit = in_flit;
            if (w_is_head && in_flit[63]) fwd_flit[62:7] = r_rm;
            if (r_fab) abs_flit = in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_idle;
            r_hdr         <= '0;
            r_fab         <= 1'b0;
            r_rm          <= '0;
            r_fwd_got     <= 1'b0;
            r_abs_got     <= 1'b0;
            fwd_port      <= '0;
            req_fwd       <= 1'b0;
            req_abs       <= 1'b0;
            release_ports <= 1'b0;
            err           <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_fab     <= w_fab_nx;
            r_fwd_got <= w_fwd_got_nx;
            r_abs_got <= w_abs_got_nx;
            if ((r_state == c_idle) && in_valid && w_is_head) r_hdr <= in_flit[63:7];
            if (r_state == c_route) begin
                fwd_port <= dec_port;
                r_rm     <= dec_addr1_rm;
            end
            req_fwd       <= (w_state_nx == c_alloc) && !w_fwd_got_nx;
            req_abs       <= (w_state_nx == c_alloc) && w_fab_nx && !w_abs_got_nx;
            release_ports <= (r_state == c_xfer) && w_xfer && w_is_tail;
            err           <= (r_state == c_idle) && in_valid && !w_is_head;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc_fork_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc_fork_ctrl
// Purpose  : Directed self-checking bench for rc_fork_ctrl.
// Revision : 1.0
// ============================================================================
module tb_rc_fork_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [65:0] in_flit;
    logic        in_ready;
    logic        dec_um_type;
    logic [10:0] dec_addr0;
    logic [55:0] dec_addr1;
    logic [2:0]  stub_port;
    logic [55:0] stub_rm;
    logic        stub_fab;
    logic        req_fwd;
    logic        req_abs;
    logic        gnt_fwd;
    logic        gnt_abs;
    logic        release_ports;
    logic        fwd_valid;
    logic [2:0]  fwd_port;
    logic [65:0] fwd_flit;
    logic        fwd_ready;
    logic        abs_valid;
    logic [65:0] abs_flit;
    logic        abs_ready;
    logic        err;

    logic [65:0] fifo[$];
    logic [65:0] fwd_log[$];
    logic [65:0] abs_log[$];
    logic [65:0] exp_fwd[$];
    logic [65:0] exp_abs[$];
    logic        in_en;
    int          n_cmp;
    int          n_mis;

    rc_fork_ctrl #(.FLIT_W(66), .PORTW(2), .LOCAL_PORT(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_ready     (in_ready),
        .dec_um_type  (dec_um_type),
        .dec_addr0    (dec_addr0),
        .dec_addr1    (dec_addr1),
        .dec_port     (stub_port),
        .dec_addr1_rm (stub_rm),
        .dec_fwdab_en (stub_fab),
        .req_fwd      (req_fwd),
        .req_abs      (req_abs),
        .gnt_fwd      (gnt_fwd),
        .gnt_abs      (gnt_abs),
        .release_ports(release_ports),
        .fwd_valid    (fwd_valid),
        .fwd_port     (fwd_port),
        .fwd_flit     (fwd_flit),
        .fwd_ready    (fwd_ready),
        .abs_valid    (abs_valid),
        .abs_flit     (abs_flit),
        .abs_ready    (abs_ready),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [65:0] fl(input logic [1:0] t, input logic [63:0] p);
        return {t, p};
    endfunction

    task automatic drive_in();
        if (in_en && fifo.size() > 0) begin
            in_valid = 1'b1;
            in_flit  = fifo[0];
        end else begin
            in_valid = 1'b0;
            in_flit  = '0;
        end
    endtask

    // Called at the falling edge: log transfers, cross the rising edge, pop.
    task automatic adv();
        logic pop;
        pop = in_valid && in_ready;
        if (fwd_valid && fwd_ready) fwd_log.push_back(fwd_flit);
        if (abs_valid && abs_ready) abs_log.push_back(abs_flit);
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) fifo.delete(0);
        gnt_fwd = 1'b0;
        gnt_abs = 1'b0;
        drive_in();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (fifo.size() > 0 && n < 20) begin
            @(negedge clk);
            adv();
            n++;
        end
        check_eq(tag, fifo.size(), 0);
    endtask

    task automatic check_logs(input string tag);
        check_eq({tag, "_fwd_n"}, fwd_log.size(), exp_fwd.size());
        check_eq({tag, "_abs_n"}, abs_log.size(), exp_abs.size());
        for (int i = 0; i < exp_fwd.size() && i < fwd_log.size(); i++)
            check_eq($sformatf("%s_fwd%0d", tag, i), fwd_log[i], exp_fwd[i]);
        for (int i = 0; i < exp_abs.size() && i < abs_log.size(); i++)
            check_eq($sformatf("%s_abs%0d", tag, i), abs_log[i], exp_abs[i]);
        fwd_log.delete();
        abs_log.delete();
        exp_fwd.delete();
        exp_abs.delete();
    endtask

    initial begin
        logic [65:0] h;
        logic [65:0] hr;
        logic [65:0] b;
        logic [65:0] b2;
        logic [65:0] t;
        n_cmp = 0; n_mis = 0;
        rst = 1'b1; in_en = 1'b0; in_valid = 1'b0; in_flit = '0;
        gnt_fwd = 1'b0; gnt_abs = 1'b0; fwd_ready = 1'b1; abs_ready = 1'b1;
        stub_port = '0; stub_rm = '0; stub_fab = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_outs", {in_ready, req_fwd, req_abs, release_ports, fwd_valid, abs_valid, err}, 7'd0);
        check_eq("rst_port", fwd_port, 0);
        check_eq("rst_dec", {dec_um_type, dec_addr0, dec_addr1}, 0);
        adv();

        // Unicast: head, two bodies, tail to port 3
        h = fl(2'b01, {1'b0, 11'd5, 52'h1}); b = fl(2'b00, 64'hB1);
        b2 = fl(2'b00, 64'hB2); t = fl(2'b10, 64'hC1);
        stub_port = 3'd3; stub_fab = 1'b0; stub_rm = 56'h0;
        fifo = '{h, b, b2, t}; in_en = 1'b1; drive_in();
        @(negedge clk); check_eq("u_c0_in_ready", in_ready, 0); adv();
        @(negedge clk); check_eq("u_dec_addr0", dec_addr0, 11'd5);
        check_eq("u_dec_addr1", dec_addr1, 0); check_eq("u_c1_req", req_fwd, 0); adv();
        gnt_fwd = 1'b1;
        @(negedge clk); check_eq("u_req_fwd", req_fwd, 1); check_eq("u_req_abs", req_abs, 0);
        check_eq("u_port", fwd_port, 3); adv();
        @(negedge clk); check_eq("u_head_valid", fwd_valid, 1); check_eq("u_head_flit", fwd_flit, h);
        check_eq("u_abs_valid", abs_valid, 0); adv();
        drain("u_drain");
        @(negedge clk); check_eq("u_release", release_ports, 1); adv();
        @(negedge clk); check_eq("u_release_pulse", release_ports, 0); adv();
        exp_fwd = '{h, b, b2, t};
        check_logs("u");

        // Fork: multicast bitmap 11 -> forward with 10 plus local copy
        h = fl(2'b01, {1'b1, 56'h11, 7'h2}); hr = fl(2'b01, {1'b1, 56'h10, 7'h2});
        b = fl(2'b00, 64'hB3); t = fl(2'b10, 64'hC3);
        stub_port = 3'd2; stub_fab = 1'b1; stub_rm = 56'h10;
        fifo = '{h, b, t}; drive_in();
        @(negedge clk); adv();
        @(negedge clk); check_eq("f_dec_um", dec_um_type, 1); check_eq("f_dec_addr1", dec_addr1, 56'h11);
        check_eq("f_dec_addr0", dec_addr0, 0); adv();
        gnt_fwd = 1'b1; gnt_abs = 1'b1;
        @(negedge clk); check_eq("f_req_abs", req_abs, 1); adv();
        @(negedge clk); check_eq("f_both_valid", {fwd_valid, abs_valid}, 2'b11);
        check_eq("f_fwd_bitmap", fwd_flit[62:7], 56'h10); check_eq("f_abs_bitmap", abs_flit[62:7], 56'h11);
        adv();
        drain("f_drain");
        @(negedge clk); check_eq("f_release", release_ports, 1); adv();
        exp_fwd = '{hr, b, t}; exp_abs = '{h, b, t};
        check_logs("f");

        // Fork with local port stalled for three cycles
        fifo = '{h, b, t}; drive_in();
        @(negedge clk); adv();
        @(negedge clk); adv();
        gnt_fwd = 1'b1; gnt_abs = 1'b1;
        @(negedge clk); adv();
        abs_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp_fwd_valid%0d", k), fwd_valid, 0);
            check_eq($sformatf("bp_in_ready%0d", k), in_ready, 0);
            adv();
        end
        abs_ready = 1'b1;
        drain("bp_drain");
        @(negedge clk); check_eq("bp_release", release_ports, 1); adv();
        exp_fwd = '{hr, b, t}; exp_abs = '{h, b, t};
        check_logs("bp");

        // Grant order: stray fwd grant in ROUTE, abs grant two cycles before fwd
        t = fl(2'b10, 64'hC4);
        fifo = '{h, t}; drive_in();
        @(negedge clk); adv();
        gnt_fwd = 1'b1;
        @(negedge clk); adv();
        gnt_abs = 1'b1;
        @(negedge clk); check_eq("g_req_abs", req_abs, 1); adv();
        @(negedge clk); check_eq("g_req_abs_drop", req_abs, 0); check_eq("g_req_fwd_hold", req_fwd, 1);
        check_eq("g_no_xfer", fwd_valid, 0); adv();
        gnt_fwd = 1'b1;
        @(negedge clk); check_eq("g_still_alloc", fwd_valid, 0); adv();
        @(negedge clk); check_eq("g_xfer", {fwd_valid, abs_valid}, 2'b11); check_eq("g_req_fwd_drop", req_fwd, 0);
        adv();
        drain("g_drain");
        @(negedge clk); check_eq("g_release", release_ports, 1); adv();
        exp_fwd = '{hr, t}; exp_abs = '{h, t};
        check_logs("g");

        // Orphan body dropped, then a single-flit packet
        b = fl(2'b00, 64'hE0); h = fl(2'b11, {1'b0, 11'd7, 52'h3});
        stub_port = 3'd1; stub_fab = 1'b0; stub_rm = 56'h0;
        fifo = '{b, h}; drive_in();
        @(negedge clk); check_eq("e_pop", in_ready, 1); check_eq("e_err0", err, 0); adv();
        @(negedge clk); check_eq("e_err", err, 1); check_eq("e_hold_head", in_ready, 0); adv();
        @(negedge clk); check_eq("e_err_pulse", err, 0); check_eq("e_dec_addr0", dec_addr0, 11'd7); adv();
        gnt_fwd = 1'b1;
        @(negedge clk); check_eq("e_req_fwd", req_fwd, 1); adv();
        @(negedge clk); check_eq("e_valid", fwd_valid, 1); check_eq("e_flit", fwd_flit, h); adv();
        @(negedge clk); check_eq("e_release", release_ports, 1); adv();
        exp_fwd = '{h};
        check_logs("e");

        // Reset in the middle of a unicast packet
        h = fl(2'b01, {1'b0, 11'd5, 52'h9}); b = fl(2'b00, 64'hB5);
        b2 = fl(2'b00, 64'hB6); t = fl(2'b10, 64'hC5);
        stub_port = 3'd3;
        fifo = '{h, b, b2, t}; drive_in();
        @(negedge clk); adv();
        @(negedge clk); adv();
        gnt_fwd = 1'b1;
        @(negedge clk); adv();
        @(negedge clk); check_eq("r_head_valid", fwd_valid, 1); adv();
        rst = 1'b1; in_en = 1'b0; drive_in();
        @(negedge clk); adv();
        rst = 1'b0;
        @(negedge clk);
        check_eq("r_outs", {in_ready, req_fwd, req_abs, release_ports, fwd_valid, abs_valid, err}, 7'd0);
        check_eq("r_port", fwd_port, 0);
        check_eq("r_flits", {fwd_flit, abs_flit}, 0);
        check_eq("r_dec", {dec_um_type, dec_addr0, dec_addr1}, 0);
        adv();
        in_en = 1'b1; drive_in();
        @(negedge clk); check_eq("r_orphan_pop", in_ready, 1); adv();
        @(negedge clk); check_eq("r_orphan_err", err, 1); adv();
        drain("r_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
